// File: rtl/ieeedrv_seek_gen_if.sv
// Seek request/response bundle between a drive controller (master)
// and the stepper-phase generator (slave).
interface ieeedrv_seek_gen_if;
    logic       start;
    logic [7:0] target_track;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cur_track;

    modport master (
        output start, target_track,
        input  busy, done, err, cur_track
    );

    modport slave (
        input  start, target_track,
        output busy, done, err, cur_track
    );
endinterface

// File: rtl/ieeedrv_seek_gen.sv
// Stepper-phase generator for the 4040/8250 head mechanism: walks the head to a
// logical target track one phase change per step period, then settles and pulses done.
module ieeedrv_seek_gen #(
    parameter int STEP_CYCLES   = 16000,
    parameter int SETTLE_CYCLES = 32000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic              drv_type,
    input  logic              mounted,
    ieeedrv_seek_gen_if.slave req,
    output logic [1:0]        stp,
    output logic              hd,
    output logic              mtr
);
    localparam int TMAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] STEP_LOAD   = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_STEP,
        S_WAIT,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t        state;
    logic [8:0]    htrack;
    logic [8:0]    tgt_h;
    logic [7:0]    tgt_t;
    logic [TW-1:0] timer;
    logic          done_r;
    logic          err_r;

    logic          t_valid;
    logic [8:0]    t_h;
    logic          t_hd;
    logic [8:0]    dir_h;

    assign dir_h = drv_type ? 9'd34 : 9'd152;

    // Logical track -> head position in half (4040) or quarter (8250) track units
    always_comb begin
        t_valid = 1'b0;
        t_h     = '0;
        t_hd    = 1'b0;
        if (drv_type) begin
            if (tgt_t >= 8'd1 && tgt_t <= 8'd43) begin
                t_valid = 1'b1;
                t_h     = {1'b0, tgt_t - 8'd1} << 1;
            end
        end else if (tgt_t >= 8'd1 && tgt_t <= 8'd77) begin
            t_valid = 1'b1;
            t_h     = {1'b0, tgt_t - 8'd1} << 2;
        end else if (tgt_t >= 8'd78 && tgt_t <= 8'd154) begin
            t_valid = 1'b1;
            t_h     = {1'b0, tgt_t - 8'd78} << 2;
            t_hd    = 1'b1;
        end
    end

    assign req.cur_track = drv_type ? ({1'b0, htrack[7:1]} + 8'd1)
                                    : ({1'b0, htrack[8:2]} + (hd ? 8'd78 : 8'd1));
    assign req.busy = (state != S_IDLE);
    assign req.done = done_r;
    assign req.err  = err_r;
    assign mtr      = (state != S_IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state  <= S_IDLE;
            stp    <= '0;
            hd     <= 1'b0;
            htrack <= dir_h;
            tgt_h  <= '0;
            tgt_t  <= '0;
            timer  <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (mounted) begin
            // Re-home only; phase and side keep their last driven value
            state  <= S_IDLE;
            htrack <= dir_h;
            timer  <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req.start) begin
                        tgt_t <= req.target_track;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!t_valid) begin
                        err_r <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tgt_h <= t_h;
                        hd    <= t_hd;
                        if (htrack != t_h) begin
                            state <= S_STEP;
                        end else if (hd != t_hd) begin
                            timer <= SETTLE_LOAD;
                            state <= S_SETTLE;
                        end else begin
                            done_r <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_STEP: begin
                    if (htrack < tgt_h) begin
                        stp    <= stp + 2'd1;
                        htrack <= htrack + 9'd1;
                    end else begin
                        stp    <= stp - 2'd1;
                        htrack <= htrack - 9'd1;
                    end
                    timer <= STEP_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ce) begin
                        if (timer == '0) begin
                            if (htrack == tgt_h) begin
                                timer <= SETTLE_LOAD;
                                state <= S_SETTLE;
                            end else begin
                                state <= S_STEP;
                            end
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (ce) begin
                        if (timer == '0) begin
                            done_r <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ieeedrv_seek_gen.sv
// Scoreboard bench for ieeedrv_seek_gen: stimulus queues expected step/done/err
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_ieeedrv_seek_gen;
    localparam int STEP_N   = 4;
    localparam int SETTLE_N = 6;
    localparam int EV_STEP  = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int         kind;
        logic [1:0] stp;
        logic       hd;
        logic       chk_cur;
        logic [7:0] cur;
        int         gap;
    } exp_t;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic       ce       = 1'b1;
    logic       drv_type = 1'b0;
    logic       mounted  = 1'b0;
    logic [1:0] stp;
    logic       hd;
    logic       mtr;

    ieeedrv_seek_gen_if bus();

    ieeedrv_seek_gen #(
        .STEP_CYCLES  (STEP_N),
        .SETTLE_CYCLES(SETTLE_N)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce      (ce),
        .drv_type(drv_type),
        .mounted (mounted),
        .req     (bus),
        .stp     (stp),
        .hd      (hd),
        .mtr     (mtr)
    );

    always #5 clk_sys = ~clk_sys;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_step_cyc = 0;
    int         ev_idx = 0;
    logic [1:0] prev_stp = 2'd0;
    logic [1:0] m_stp = 2'd0;

    task automatic score(input int kind);
        exp_t e;
        int   gap;
        bit   ok;
        gap = 0;
        if (kind == EV_STEP) begin
            gap = cyc - last_step_cyc;
            last_step_cyc = cyc;
        end
        n_cmp++;
        ev_idx++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event_%0d: got kind=%0d stp=%0d hd=%0d cur=%0d, required no event",
                     ev_idx, kind, stp, hd, bus.cur_track);
            return;
        end
        e = sb.pop_front();
        ok = (kind == e.kind) && (stp === e.stp) && (hd === e.hd) &&
             (!e.chk_cur || bus.cur_track === e.cur) && (e.gap == 0 || gap == e.gap);
        if (!ok) begin
            n_bad++;
            $display("FAIL event_%0d: got kind=%0d stp=%0d hd=%0d cur=%0d gap=%0d, required kind=%0d stp=%0d hd=%0d cur=%0d gap=%0d",
                     ev_idx, kind, stp, hd, bus.cur_track, gap, e.kind, e.stp, e.hd, e.cur, e.gap);
        end
    endtask

    always @(negedge clk_sys) begin
        cyc++;
        if (!reset) begin
            if (stp !== prev_stp) score(EV_STEP);
            if (bus.done === 1'b1) score(EV_DONE);
            if (bus.err === 1'b1) score(EV_ERR);
        end
        prev_stp = stp;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [1:0] s, input logic h,
                        input logic cc, input logic [7:0] c, input int g);
        exp_t e;
        e.kind = kind; e.stp = s; e.hd = h; e.chk_cur = cc; e.cur = c; e.gap = g;
        sb.push_back(e);
    endtask

    // Queue n phase changes from the model phase; the first gap is never timed
    task automatic push_steps(input int n, input bit inward, input logic h, input int untimed_idx);
        for (int i = 0; i < n; i++) begin
            m_stp = inward ? m_stp + 2'd1 : m_stp - 2'd1;
            push(EV_STEP, m_stp, h, 1'b0, 8'd0, (i == 0 || i == untimed_idx) ? 0 : STEP_N + 1);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset(input logic dt);
        drv_type = dt;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        m_stp = 2'd0;
        tick(1);
    endtask

    task automatic issue(input logic [7:0] t);
        bus.target_track = t;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < max_cycles) begin
            tick(1);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got busy=%0d after %0d cycles, required busy=0", name, bus.busy, n);
        end
        tick(2);
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.target_track = 8'd0;

        do_reset(1'b0);
        check("rst_stp", 32'(stp), 0);
        check("rst_hd", 32'(hd), 0);
        check("rst_cur_8250", 32'(bus.cur_track), 39);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_mtr", 32'(mtr), 0);
        check("rst_done_err", {30'd0, bus.done, bus.err}, 0);
        do_reset(1'b1);
        check("rst_cur_4040", 32'(bus.cur_track), 18);

        // 8250 inward seek 39 -> 40: four quarter-track steps
        do_reset(1'b0);
        push_steps(4, 1'b1, 1'b0, -1);
        push(EV_DONE, 2'd0, 1'b0, 1'b1, 8'd40, 0);
        issue(8'd40);
        check("seek40_mtr", 32'(mtr), 1);
        wait_idle("seek40", 200);
        check("seek40_cur", 32'(bus.cur_track), 40);

        // Re-home while idle, then cross to side 1 track 78 (htrack 152 -> 0)
        mounted = 1'b1;
        tick(1);
        mounted = 1'b0;
        check("mount_cur", 32'(bus.cur_track), 39);
        check("mount_stp", 32'(stp), 0);
        push_steps(152, 1'b0, 1'b1, -1);
        push(EV_DONE, 2'd0, 1'b1, 1'b1, 8'd78, 0);
        issue(8'd78);
        tick(1);
        check("side1_hd_in_check", 32'(hd), 1);
        check("side1_busy", 32'(bus.busy), 1);
        wait_idle("seek78", 2000);
        check("seek78_cur", 32'(bus.cur_track), 78);
        check("seek78_stp", 32'(stp), 0);

        // 4040 target validation
        do_reset(1'b1);
        push(EV_ERR, 2'd0, 1'b0, 1'b1, 8'd18, 0);
        issue(8'd44);
        wait_idle("err44", 20);
        check("err44_busy", 32'(bus.busy), 0);
        check("err44_stp", 32'(stp), 0);
        push(EV_ERR, 2'd0, 1'b0, 1'b1, 8'd18, 0);
        issue(8'd0);
        wait_idle("err0", 20);
        push(EV_DONE, 2'd0, 1'b0, 1'b1, 8'd18, 0);
        issue(8'd18);
        wait_idle("same18", 20);
        check("same18_cur", 32'(bus.cur_track), 18);

        // mounted mid-seek: two steps out of 84, then abort without done
        do_reset(1'b0);
        push_steps(2, 1'b1, 1'b0, -1);
        issue(8'd60);
        tick(9);
        mounted = 1'b1;
        tick(1);
        mounted = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_cur", 32'(bus.cur_track), 39);
        check("abort_stp", 32'(stp), 2);
        tick(20);
        check("abort_sb_empty", 32'(sb.size()), 0);

        // start while busy must not retarget the seek
        do_reset(1'b0);
        push_steps(8, 1'b1, 1'b0, -1);
        push(EV_DONE, 2'd0, 1'b0, 1'b1, 8'd41, 0);
        issue(8'd41);
        tick(12);
        issue(8'd1);
        wait_idle("busy_start", 300);
        check("busy_start_cur", 32'(bus.cur_track), 41);

        // ce low in WAIT freezes the step timer
        do_reset(1'b0);
        push_steps(4, 1'b1, 1'b0, 1);
        push(EV_DONE, 2'd0, 1'b0, 1'b1, 8'd40, 0);
        issue(8'd40);
        tick(3);
        ce = 1'b0;
        tick(20);
        check("ce_low_stp", 32'(stp), 1);
        check("ce_low_busy", 32'(bus.busy), 1);
        ce = 1'b1;
        wait_idle("ce_low", 300);
        check("ce_low_cur", 32'(bus.cur_track), 40);

        tick(5);
        check("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
